// File: rtl/device_pkg.sv
// Shared definitions for the memory-mapped register front end used by bus peripherals.
package device_pkg;

    localparam int unsigned DEV_ADDR_W = 4;
    localparam int unsigned DEV_DATA_W = 8;
    localparam int unsigned DEV_N_REGS = 16;

    typedef logic [7:0] dev_byte_t;

    localparam logic DEV_MODE_READ  = 1'b0;
    localparam logic DEV_MODE_WRITE = 1'b1;

endpackage

// File: rtl/device_interface.sv
// Register bank written and read over a simple address/enable/mode bus strobe,
// with every register also exposed in parallel to the owning device core.
module device_interface
    import device_pkg::*;
#(
    parameter int unsigned N_REGS = DEV_N_REGS,
    parameter int unsigned DATA_W = DEV_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(N_REGS)-1:0]  address,
    input  logic                       enable,
    input  logic                       mode,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          data_out,
    output logic [DATA_W-1:0]          device_data [N_REGS-1:0]
);

    logic [DATA_W-1:0] regs [N_REGS-1:0];
    logic              wr_en;
    logic              rd_en;

    assign wr_en = enable && (mode == DEV_MODE_WRITE);
    assign rd_en = enable && (mode == DEV_MODE_READ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[address] <= data_in;
        end
    end

    // Idle and write cycles drive zero so several devices can OR onto one bus.
    always_comb begin
        data_out = '0;
        if (rd_en) begin
            data_out = regs[address];
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_dev_data
        assign device_data[g] = regs[g];
    end

endmodule

// File: tb/tb_device_interface.sv
// Self-checking bench for device_interface: reference register model plus a
// scoreboard queue of expected read data.
module tb_device_interface;

    logic       clk;
    logic       rst_n;
    logic [3:0] address;
    logic       enable;
    logic       mode;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] device_data [15:0];

    logic [7:0] model [16];
    logic [7:0] sb [$];
    int unsigned n_checks;
    int unsigned n_fail;

    device_interface #(.N_REGS(16), .DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address     (address),
        .enable      (enable),
        .mode        (mode),
        .data_in     (data_in),
        .data_out    (data_out),
        .device_data (device_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_dd%0d", tag, i), device_data[i], model[i]);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
    endtask

    // Drives a write for one cycle; enable stays high until the next task changes it.
    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        enable  = 1'b1;
        mode    = 1'b1;
        address = a;
        data_in = d;
        #1;
        check("wr_dout_idle", data_out, 8'h00);
        @(posedge clk);
        #1;
        model[a] = d;
        check($sformatf("wr_dd%0d", a), device_data[a], model[a]);
    endtask

    task automatic do_read(input logic [3:0] a);
        logic [7:0] exp;
        @(negedge clk);
        enable  = 1'b1;
        mode    = 1'b0;
        address = a;
        data_in = 8'hEE;
        sb.push_back(model[a]);
        #1;
        exp = sb.pop_front();
        check($sformatf("rd%0d", a), data_out, exp);
    endtask

    task automatic go_idle();
        @(negedge clk);
        enable = 1'b0;
        mode   = 1'b0;
        #1;
        check("idle_dout", data_out, 8'h00);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        enable   = 1'b0;
        mode     = 1'b0;
        address  = '0;
        data_in  = '0;
        clear_model();

        // Asynchronous reset between edges: bank must clear before any clock.
        #7;
        rst_n = 1'b0;
        #1;
        check_bank("rst");
        check("rst_dout", data_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write / read
        do_write(4'd3, 8'hA5);
        go_idle();
        check_bank("single");
        do_read(4'd3);

        // Full sweep
        for (int i = 0; i < 16; i++) do_write(4'(i), 8'(i * 17));
        go_idle();
        check_bank("sweep");
        for (int i = 0; i < 16; i++) do_read(4'(i));

        // Disabled access must not change anything
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            enable  = 1'b0;
            mode    = 1'b1;
            address = 4'(i);
            data_in = 8'hFF;
            #1;
            check("dis_dout", data_out, 8'h00);
        end
        @(posedge clk);
        #1;
        check_bank("disabled");

        // Overwrite and isolation
        do_write(4'd9, 8'h10);
        do_write(4'd9, 8'h20);
        go_idle();
        check("ovr_dd9", device_data[9], 8'h20);
        check_bank("ovr");
        do_read(4'd8);
        do_read(4'd9);
        do_read(4'd10);

        // Reset asserted during a write
        do_write(4'd15, 8'h7F);
        @(negedge clk);
        enable  = 1'b1;
        mode    = 1'b1;
        address = 4'd15;
        data_in = 8'h55;
        #1;
        rst_n = 1'b0;
        clear_model();
        #1;
        check("rstw_dd15_async", device_data[15], 8'h00);
        @(posedge clk);
        #1;
        check("rstw_dd15_edge1", device_data[15], 8'h00);
        check("rstw_dout", data_out, 8'h00);
        @(posedge clk);
        #1;
        check("rstw_dd15_edge2", device_data[15], 8'h00);
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b1;
        #1;
        check_bank("rstw");

        // First edge after release accepts a write
        do_write(4'd2, 8'h3C);
        go_idle();
        do_read(4'd2);

        // Random mixed traffic against the model
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(1, 0) == 1)
                do_write(4'($urandom_range(15, 0)), 8'($urandom_range(255, 0)));
            else
                do_read(4'($urandom_range(15, 0)));
        end
        go_idle();
        check_bank("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
